// File: rtl/enemy_dive_sched.sv
// enemy_dive_sched: picks the next formation enemy to break off into a dive.
// Waits a frame-based cooldown, scans the eligible set in round-robin order
// (alive and not already diving), and hands the winner to the dive-path
// engine over a valid/ready handshake while capping simultaneous divers.
`timescale 1ns/1ps

module enemy_dive_sched #(
  parameter  int NUM_ENEMIES = 16,
  parameter  int COOLDOWN    = 120,
  parameter  int MAX_DIVERS  = 2,
  localparam int IDW         = $clog2(NUM_ENEMIES),
  localparam int CW          = $clog2(MAX_DIVERS + 1)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   frame_i,
  input  logic                   pause_i,
  input  logic [NUM_ENEMIES-1:0] alive_i,
  input  logic                   done_i,
  input  logic [IDW-1:0]         done_id_i,
  output logic                   dive_valid_o,
  output logic [IDW-1:0]         dive_id_o,
  input  logic                   dive_ready_i,
  output logic [NUM_ENEMIES-1:0] diving_o,
  output logic [CW-1:0]          active_cnt_o
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSearch = 2'd1,
    StIssue  = 2'd2
  } state_e;

  localparam logic [9:0]   COOLDOWN_V = 10'(COOLDOWN);
  localparam logic [CW-1:0] MAX_V     = CW'(MAX_DIVERS);
  // Scan index of the final candidate in a full lap of the formation.
  localparam logic [IDW:0] SCAN_LAST  = (IDW + 1)'(NUM_ENEMIES - 1);

  state_e                 state_q, state_d;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [9:0]             cd_q, cd_d;
  logic [IDW:0]           scan_q, scan_d;
  logic [NUM_ENEMIES-1:0] diving_q, diving_d;
  logic [CW-1:0]          active_q, active_d;
  logic                   valid_q, valid_d;
  logic [IDW-1:0]         id_q, id_d;

  logic [NUM_ENEMIES-1:0] set_mask, clr_mask;
  logic                   inc, dec;
  logic                   cand_ok;

  // Next-state logic for the scheduler FSM, pointer, cooldown and diver set.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cd_d     = cd_q;
    scan_d   = scan_q;
    valid_d  = valid_q;
    id_d     = id_q;
    set_mask = '0;
    clr_mask = '0;
    inc      = 1'b0;
    dec      = 1'b0;
    cand_ok  = alive_i[ptr_q] & ~diving_q[ptr_q];

    // Completion is honoured in every state, including while paused; a done
    // for an enemy that is not diving is dropped so active cannot underflow.
    if (done_i && diving_q[done_id_i]) begin
      clr_mask[done_id_i] = 1'b1;
      dec                 = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (!pause_i) begin
          if (cd_q != 10'd0) begin
            if (frame_i) cd_d = cd_q - 10'd1;
          end else if (active_q < MAX_V) begin
            state_d = StSearch;
            scan_d  = '0;
          end
        end
      end

      StSearch: begin
        if (!pause_i) begin
          if (cand_ok) begin
            state_d = StIssue;
            valid_d = 1'b1;
            id_d    = ptr_q;
          end else begin
            ptr_d = ptr_q + IDW'(1);
            if (scan_q == SCAN_LAST) begin
              // A full lap found nobody: back off for another cooldown.
              state_d = StIdle;
              cd_d    = COOLDOWN_V;
              scan_d  = '0;
            end else begin
              scan_d = scan_q + (IDW + 1)'(1);
            end
          end
        end
      end

      StIssue: begin
        // The command is held regardless of pause or the target dying; only
        // the engine's acceptance retires it.
        if (dive_ready_i) begin
          set_mask[id_q] = 1'b1;
          inc            = 1'b1;
          ptr_d          = id_q + IDW'(1);
          cd_d           = COOLDOWN_V;
          state_d        = StIdle;
          valid_d        = 1'b0;
        end
      end

      default: state_d = StIdle;
    endcase

    diving_d = (diving_q | set_mask) & ~clr_mask;
    active_d = active_q + CW'(inc) - CW'(dec);
  end

  // State register; reset drops the command and clears the diver set at once.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      cd_q     <= COOLDOWN_V;
      scan_q   <= '0;
      // NOTE: the diver mask is a flag register, not a memory, so it is reset
      // like any other state; a stale bit would permanently block that slot.
      diving_q <= '0;
      active_q <= '0;
      valid_q  <= 1'b0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cd_q     <= cd_d;
      scan_q   <= scan_d;
      diving_q <= diving_d;
      active_q <= active_d;
      valid_q  <= valid_d;
      id_q     <= id_d;
    end
  end

  assign dive_valid_o = valid_q;
  assign dive_id_o    = id_q;
  assign diving_o     = diving_q;
  assign active_cnt_o = active_q;

endmodule
